// File: rtl/ex_multi_ctrl.sv
// Multi-register transfer sequencer: steps through LDM/STM register lists and
// SWP read/write pairs, producing one memory beat per non-stalled cycle.
module ex_multi_ctrl #(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 16,
  parameter  int STEP   = 4,
  localparam int RC_W   = $clog2(NREG)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [1:0]               i_mode,
  input  logic [NREG-1:0]          i_reglist,
  input  logic                     i_up,
  input  logic                     i_wb_base,
  input  logic [RC_W-1:0]          i_rd_code,
  input  logic                     i_stall,
  output logic                     o_busy,
  output logic                     o_mem_vld,
  output logic                     o_is_store,
  output logic signed [DATA_W-1:0] o_offset,
  output logic [RC_W-1:0]          o_reg_code,
  output logic                     o_wb_rd_vld,
  output logic                     o_base_wb_vld,
  output logic signed [DATA_W-1:0] o_base_delta,
  output logic                     o_done
);

  localparam logic [1:0] MODE_LDM = 2'b00;
  localparam logic [1:0] MODE_STM = 2'b01;
  localparam logic [1:0] MODE_SWP = 2'b10;
  localparam logic signed [DATA_W-1:0] STEP_S = DATA_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XFER   = 2'd1,
    S_SWP_RD = 2'd2,
    S_SWP_WR = 2'd3
  } state_t;

  function automatic logic [RC_W:0] f_popcount(input logic [NREG-1:0] v);
    logic [RC_W:0] c;
    c = '0;
    for (int k = 0; k < NREG; k++) c = c + (RC_W+1)'(v[k]);
    return c;
  endfunction

  function automatic logic [RC_W-1:0] f_lowest(input logic [NREG-1:0] v);
    logic [RC_W-1:0] idx;
    idx = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (v[k]) idx = RC_W'(k);
    end
    return idx;
  endfunction

  state_t                   r_state, w_state_nxt;
  logic [NREG-1:0]          r_list, w_list_nxt;
  logic                     r_store, w_store_nxt;
  logic                     r_wb_base, w_wb_base_nxt;
  logic [RC_W-1:0]          r_rd, w_rd_nxt;
  logic signed [DATA_W-1:0] r_offset, w_offset_nxt;
  logic signed [DATA_W-1:0] r_delta, w_delta_nxt;
  logic                     r_done_pend, w_done_pend_nxt;

  logic [RC_W:0]            w_cnt;
  logic signed [DATA_W-1:0] w_mag;
  logic [NREG-1:0]          w_lsb;
  logic                     w_final;

  assign w_cnt   = f_popcount(i_reglist);
  assign w_mag   = STEP_S * $signed(DATA_W'(w_cnt));
  // Two's-complement trick isolates the lowest remaining set bit.
  assign w_lsb   = r_list & (-r_list);
  assign w_final = (r_list & ~w_lsb) == '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_list      <= '0;
      r_store     <= 1'b0;
      r_wb_base   <= 1'b0;
      r_rd        <= '0;
      r_offset    <= '0;
      r_delta     <= '0;
      r_done_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_list      <= w_list_nxt;
      r_store     <= w_store_nxt;
      r_wb_base   <= w_wb_base_nxt;
      r_rd        <= w_rd_nxt;
      r_offset    <= w_offset_nxt;
      r_delta     <= w_delta_nxt;
      r_done_pend <= w_done_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_list_nxt      = r_list;
    w_store_nxt     = r_store;
    w_wb_base_nxt   = r_wb_base;
    w_rd_nxt        = r_rd;
    w_offset_nxt    = r_offset;
    w_delta_nxt     = r_delta;
    w_done_pend_nxt = r_done_pend;
    if (!i_stall) begin
      w_done_pend_nxt = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if ((i_mode == MODE_LDM || i_mode == MODE_STM) && (i_reglist != '0)) begin
              w_list_nxt    = i_reglist;
              w_store_nxt   = (i_mode == MODE_STM);
              w_wb_base_nxt = i_wb_base;
              // Descending transfers start at the lowest address of the block.
              w_offset_nxt  = i_up ? '0 : -w_mag;
              w_delta_nxt   = i_up ? w_mag : -w_mag;
              w_state_nxt   = S_XFER;
            end else if (i_mode == MODE_SWP) begin
              w_rd_nxt    = i_rd_code;
              w_state_nxt = S_SWP_RD;
            end else begin
              w_done_pend_nxt = 1'b1;
            end
          end
        end
        S_XFER: begin
          w_list_nxt   = r_list & ~w_lsb;
          w_offset_nxt = r_offset + STEP_S;
          if (w_final) begin
            w_offset_nxt = '0;
            w_state_nxt  = S_IDLE;
          end
        end
        S_SWP_RD: w_state_nxt = S_SWP_WR;
        S_SWP_WR: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_mem_vld     = 1'b0;
    o_is_store    = 1'b0;
    o_offset      = '0;
    o_reg_code    = '0;
    o_wb_rd_vld   = 1'b0;
    o_base_wb_vld = 1'b0;
    o_base_delta  = '0;
    o_done        = 1'b0;
    unique case (r_state)
      S_IDLE: o_done = r_done_pend & ~i_stall;
      S_XFER: begin
        o_mem_vld     = 1'b1;
        o_is_store    = r_store;
        o_offset      = r_offset;
        o_reg_code    = f_lowest(r_list);
        o_wb_rd_vld   = ~r_store & ~i_stall;
        o_base_delta  = r_delta;
        o_done        = w_final & ~i_stall;
        o_base_wb_vld = w_final & r_wb_base & ~i_stall;
      end
      S_SWP_RD: begin
        o_mem_vld  = 1'b1;
        o_reg_code = r_rd;
      end
      S_SWP_WR: begin
        o_mem_vld   = 1'b1;
        o_is_store  = 1'b1;
        o_reg_code  = r_rd;
        o_wb_rd_vld = ~i_stall;
        o_done      = ~i_stall;
      end
      default: o_busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ex_multi_ctrl.sv
// Scoreboard bench for ex_multi_ctrl: each test pushes the expected beat
// stream, a negedge monitor pops and compares every valid memory beat.
module tb_ex_multi_ctrl;
  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int STEP   = 4;
  localparam int RC_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [1:0]        i_mode;
  logic [NREG-1:0]   i_reglist;
  logic              i_up;
  logic              i_wb_base;
  logic [RC_W-1:0]   i_rd_code;
  logic              i_stall;
  logic              o_busy, o_mem_vld, o_is_store, o_wb_rd_vld, o_base_wb_vld, o_done;
  logic [DATA_W-1:0] o_offset, o_base_delta;
  logic [RC_W-1:0]   o_reg_code;

  always #5 clk = ~clk;

  ex_multi_ctrl #(.DATA_W(DATA_W), .NREG(NREG), .STEP(STEP)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_mode(i_mode),
    .i_reglist(i_reglist), .i_up(i_up), .i_wb_base(i_wb_base),
    .i_rd_code(i_rd_code), .i_stall(i_stall), .o_busy(o_busy),
    .o_mem_vld(o_mem_vld), .o_is_store(o_is_store), .o_offset(o_offset),
    .o_reg_code(o_reg_code), .o_wb_rd_vld(o_wb_rd_vld),
    .o_base_wb_vld(o_base_wb_vld), .o_base_delta(o_base_delta), .o_done(o_done)
  );

  typedef struct {
    logic        st;
    logic [31:0] off;
    logic [3:0]  code;
    bit          chk_code;
    logic        wb;
    logic        done;
    logic        bwb;
    logic [31:0] delta;
    bit          chk_delta;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  function automatic beat_t mk(input logic st, input logic [31:0] off, input logic [3:0] code,
                               input bit chk_code, input logic wb, input logic done,
                               input logic bwb, input logic [31:0] delta, input bit chk_delta);
    beat_t b;
    b.st = st; b.off = off; b.code = code; b.chk_code = chk_code; b.wb = wb;
    b.done = done; b.bwb = bwb; b.delta = delta; b.chk_delta = chk_delta;
    return b;
  endfunction

  // Reference beat stream for an unstalled LDM/STM, offsets from closed form.
  task automatic push_seq(input logic [1:0] m, input logic [15:0] l, input logic up, input logic wb);
    int n;
    int idx;
    logic [31:0] off;
    logic [31:0] dl;
    n = $countones(l);
    idx = 0;
    dl = up ? 32'(STEP * n) : -32'(STEP * n);
    for (int k = 0; k < NREG; k++) begin
      if (l[k]) begin
        off = up ? 32'(STEP * idx) : -32'(STEP * (n - idx));
        sb.push_back(mk(m == 2'b01, off, 4'(k), 1'b1, m == 2'b00, idx == n - 1,
                        (idx == n - 1) && wb, dl, idx == n - 1));
        idx++;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
      if (o_mem_vld) begin
        beat_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got code=%0d off=%0h, required no beat", o_reg_code, o_offset);
        end else begin
          e = sb.pop_front();
          if ({o_is_store, o_offset, o_wb_rd_vld, o_done, o_base_wb_vld} !== {e.st, e.off, e.wb, e.done, e.bwb}) begin
            errors++;
            $display("FAIL beat_fields: got st=%0b off=%0h wb=%0b done=%0b bwb=%0b, required st=%0b off=%0h wb=%0b done=%0b bwb=%0b",
                     o_is_store, o_offset, o_wb_rd_vld, o_done, o_base_wb_vld, e.st, e.off, e.wb, e.done, e.bwb);
          end
          if (e.chk_code) begin
            checks++;
            if (o_reg_code !== e.code) begin
              errors++;
              $display("FAIL beat_code: got %0d, required %0d", o_reg_code, e.code);
            end
          end
          if (e.chk_delta) begin
            checks++;
            if (o_base_delta !== e.delta) begin
              errors++;
              $display("FAIL beat_delta: got %0h, required %0h", o_base_delta, e.delta);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [1:0] m, input logic [15:0] l, input logic up, input logic wb,
                      input logic [3:0] rd);
    tick();
    i_start = 1'b1; i_mode = m; i_reglist = l; i_up = up; i_wb_base = wb; i_rd_code = rd;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; i_start = 1'b0; i_mode = 2'b00; i_reglist = '0; i_up = 1'b0;
    i_wb_base = 1'b0; i_rd_code = '0; i_stall = 1'b0;
    #2;
    checks++;
    if ({o_busy, o_mem_vld, o_is_store, o_offset, o_reg_code, o_wb_rd_vld, o_base_wb_vld, o_base_delta, o_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b vld=%0b off=%0h, required all zero", o_busy, o_mem_vld, o_offset);
    end
    i_start = 1'b1; i_mode = 2'b00; i_reglist = 16'h0001; i_up = 1'b1;
    tick();
    checks++;
    if ({o_busy, o_mem_vld, o_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: got busy=%0b vld=%0b done=%0b, required 0", o_busy, o_mem_vld, o_done);
    end
    push_seq(2'b00, 16'h0001, 1'b1, 1'b0);
    busy_cnt = 0;
    rst = 1'b0;
    tick();
    i_start = 1'b0;
    wait_idle(20, ok);
    checks++;
    if (!ok || sb.size() != 0 || busy_cnt != 1) begin
      errors++;
      $display("FAIL reset_first_start: got ok=%0b left=%0d busy=%0d, required ok=1 left=0 busy=1", ok, sb.size(), busy_cnt);
    end
  endtask

  task automatic run_seq(input string name, input logic [1:0] m, input logic [15:0] l,
                         input logic up, input logic wb, input int exp_busy);
    bit ok;
    push_seq(m, l, up, wb);
    busy_cnt = 0;
    kick(m, l, up, wb, 4'd0);
    wait_idle(40, ok);
    checks++;
    if (!ok || sb.size() != 0 || busy_cnt != exp_busy) begin
      errors++;
      $display("FAIL %s: got ok=%0b left=%0d busy=%0d, required ok=1 left=0 busy=%0d", name, ok, sb.size(), busy_cnt, exp_busy);
    end
  endtask

  task automatic test_ldm_stm();
    run_seq("ldm_up_0015", 2'b00, 16'h0015, 1'b1, 1'b1, 3);
    run_seq("stm_down_8001", 2'b01, 16'h8001, 1'b0, 1'b1, 2);
    run_seq("ldm_down_00f0", 2'b00, 16'h00F0, 1'b0, 1'b0, 4);
    run_seq("stm_full_up", 2'b01, 16'hFFFF, 1'b1, 1'b1, 16);
  endtask

  task automatic test_swp();
    bit ok;
    sb.push_back(mk(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    sb.push_back(mk(1'b1, 32'd0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0));
    busy_cnt = 0;
    kick(2'b10, 16'h0000, 1'b0, 1'b1, 4'd3);
    wait_idle(20, ok);
    checks++;
    if (!ok || sb.size() != 0 || busy_cnt != 2) begin
      errors++;
      $display("FAIL swp_basic: got ok=%0b left=%0d busy=%0d, required ok=1 left=0 busy=2", ok, sb.size(), busy_cnt);
    end
    sb.push_back(mk(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    sb.push_back(mk(1'b1, 32'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    sb.push_back(mk(1'b1, 32'd0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0));
    busy_cnt = 0;
    tick();
    i_start = 1'b1; i_mode = 2'b10; i_rd_code = 4'd5;
    tick();
    i_start = 1'b0;
    tick();
    i_stall = 1'b1;
    tick();
    i_stall = 1'b0;
    wait_idle(20, ok);
    checks++;
    if (!ok || sb.size() != 0 || busy_cnt != 3) begin
      errors++;
      $display("FAIL swp_stalled: got ok=%0b left=%0d busy=%0d, required ok=1 left=0 busy=3", ok, sb.size(), busy_cnt);
    end
  endtask

  task automatic test_stall();
    bit ok;
    sb.push_back(mk(1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd8, 1'b1));
    sb.push_back(mk(1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd8, 1'b1));
    sb.push_back(mk(1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8, 1'b1));
    sb.push_back(mk(1'b0, 32'd4, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 1'b1));
    busy_cnt = 0;
    tick();
    i_start = 1'b1; i_mode = 2'b00; i_reglist = 16'h0003; i_up = 1'b1; i_wb_base = 1'b1;
    tick();
    i_start = 1'b0; i_stall = 1'b1;
    tick();
    tick();
    i_stall = 1'b0;
    wait_idle(20, ok);
    checks++;
    if (!ok || sb.size() != 0 || busy_cnt != 4) begin
      errors++;
      $display("FAIL stall_ldm: got ok=%0b left=%0d busy=%0d, required ok=1 left=0 busy=4", ok, sb.size(), busy_cnt);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    push_seq(2'b00, 16'hFFFF, 1'b1, 1'b1);
    while (sb.size() > 5) void'(sb.pop_back());
    kick(2'b00, 16'hFFFF, 1'b1, 1'b1, 4'd0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_mem_vld, o_is_store, o_offset, o_reg_code, o_wb_rd_vld, o_base_wb_vld, o_base_delta, o_done} !== '0
        || sb.size() != 0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%0b vld=%0b code=%0d left=%0d, required all zero left=0", o_busy, o_mem_vld, o_reg_code, sb.size());
    end
    tick();
    rst = 1'b0;
    run_seq("restart_full", 2'b00, 16'hFFFF, 1'b1, 1'b1, 16);
  endtask

  task automatic test_empty();
    for (int c = 0; c < 2; c++) begin
      busy_cnt = 0;
      tick();
      i_start = 1'b1; i_mode = (c == 0) ? 2'b00 : 2'b11; i_reglist = (c == 0) ? 16'h0000 : 16'h00FF;
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0) begin
        errors++;
        $display("FAIL empty_pre_%0d: got done=%0b, required 0", c, o_done);
      end
      tick();
      i_start = 1'b0;
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1) begin
        errors++;
        $display("FAIL empty_pulse_%0d: got done=%0b, required 1", c, o_done);
      end
      tick();
      @(negedge clk);
      #1;
      checks++;
      if (o_done !== 1'b0 || busy_cnt != 0) begin
        errors++;
        $display("FAIL empty_post_%0d: got done=%0b busy=%0d, required done=0 busy=0", c, o_done, busy_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    push_seq(2'b00, 16'h0006, 1'b1, 1'b0);
    push_seq(2'b01, 16'h0002, 1'b0, 1'b0);
    busy_cnt = 0;
    tick();
    i_start = 1'b1; i_mode = 2'b00; i_reglist = 16'h0006; i_up = 1'b1; i_wb_base = 1'b0;
    tick();
    i_mode = 2'b10; i_rd_code = 4'd9;
    tick();
    i_start = 1'b0;
    tick();
    i_start = 1'b1; i_mode = 2'b01; i_reglist = 16'h0002; i_up = 1'b0;
    tick();
    i_start = 1'b0;
    wait_idle(20, ok);
    checks++;
    if (!ok || sb.size() != 0 || busy_cnt != 3) begin
      errors++;
      $display("FAIL back_to_back: got ok=%0b left=%0d busy=%0d, required ok=1 left=0 busy=3", ok, sb.size(), busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ldm_stm();
    test_swp();
    test_stall();
    test_mid_reset();
    test_empty();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/ex_multi_ctrl.md
EX_MULTI_CTRL -- requirements
Module: ex_multi_ctrl

Interface
REQ-001 Parameter DATA_W, 32, operand/offset width.
REQ-002 Parameter NREG, 16, register-list width; register code width RC_W = clog2(NREG).
REQ-003 Parameter STEP, 4, address increment per transfer beat.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_start  in  1  launch request; sampled only in IDLE.
REQ-007 i_mode  in  2  00 LDM, 01 STM, 10 SWP, 11 reserved.
REQ-008 i_reglist  in  NREG  register list; bit k selects register k.
REQ-009 i_up  in  1  1 increment addressing, 0 decrement.
REQ-010 i_wb_base  in  1  base writeback requested.
REQ-011 i_rd_code  in  RC_W  SWP destination register.
REQ-012 i_stall  in  1  downstream hold; freezes all state.
REQ-013 o_busy  out  1  sequence in progress; pipeline must hold fetch/decode.
REQ-014 o_mem_vld  out  1  memory beat valid this cycle.
REQ-015 o_is_store  out  1  beat is a write.
REQ-016 o_offset  out  DATA_W  signed offset from base for this beat.
REQ-017 o_reg_code  out  RC_W  register read (store) or written (load) this beat.
REQ-018 o_wb_rd_vld  out  1  register writeback enable this beat.
REQ-019 o_base_wb_vld  out  1  base-register update enable.
REQ-020 o_base_delta  out  DATA_W  signed base delta = +/-STEP*popcount(list).
REQ-021 o_done  out  1  single-cycle completion pulse.

Function
REQ-022 States IDLE, XFER, SWP_RD, SWP_WR; all outputs decode from registered state plus i_stall only.
REQ-023 IDLE & i_start & mode LDM/STM & list nonzero: latch list, mode, up, wb_base; next XFER.
REQ-024 IDLE & i_start & mode SWP: latch rd_code; next SWP_RD.
REQ-025 IDLE & i_start & empty list or mode 11: no beat; o_done pulses next cycle; state stays IDLE.
REQ-026 XFER: one beat per non-stalled cycle, lowest set register first; o_reg_code = index of lowest remaining set bit.
REQ-027 Offsets: up -> 0, STEP, 2*STEP...; down -> -STEP*N, -STEP*(N-1)..., N = popcount of latched list, arithmetic modulo 2^DATA_W.
REQ-028 After each non-stalled beat clear that bit; beat clearing the last bit is final; next state IDLE.
REQ-029 XFER: o_mem_vld=1; o_is_store=1 for STM; o_wb_rd_vld=1 only for LDM.
REQ-030 SWP_RD: o_mem_vld=1, o_is_store=0, o_wb_rd_vld=0, offset 0; next SWP_WR.
REQ-031 SWP_WR: o_mem_vld=1, o_is_store=1, o_wb_rd_vld=1, o_reg_code=latched rd, offset 0; next IDLE.
REQ-032 o_done and o_base_wb_vld (if latched wb_base, LDM/STM only) assert during final beat when i_stall=0.
REQ-033 i_stall=1: state, list, offset frozen; outputs held; o_done, o_base_wb_vld, o_wb_rd_vld forced 0.
REQ-034 o_busy=1 in every state except IDLE; i_start outside IDLE ignored.
REQ-035 Full list (all NREG bits) completes in exactly NREG non-stalled beats; final offset wraps nowhere other than DATA_W.

Reset
REQ-036 i_rst asserted at any time, including mid-sequence: state IDLE, latched list 0, offset 0, all outputs 0, asynchronously.
REQ-037 First i_start honoured on first clock edge after i_rst deasserts.

Verification
REQ-038 LDM, list 0x0015, up, wb_base -> three beats codes 0,2,4, offsets 0,4,8, wb_rd_vld each beat, final beat o_done=1, base_delta=+12.
REQ-039 STM, list 0x8001, down -> beats code 0 offset -8, code 15 offset -4, is_store=1, wb_rd_vld=0.
REQ-040 SWP rd=3 -> SWP_RD (load, wb 0) then SWP_WR (store, wb_rd_vld=1, code 3), o_done on second cycle.
REQ-041 LDM list 0x0003 with i_stall high on first beat for 2 cycles -> code 0 held 3 cycles, wb_rd_vld 0 while stalled, total 4 busy cycles.
REQ-042 LDM list 0xFFFF, rst pulsed after 5th beat -> outputs 0 immediately, IDLE; restart runs full 16 beats.
REQ-043 Start with empty list -> no o_mem_vld, one o_done pulse, o_busy stays 0.
